// File: rtl/adc_scan_ctrl_pkg.sv
// Shared types and helpers for the ADC scan sequencer.
// Mask search works on a 16-bit mask so one function serves every channel count.
package adc_scan_pkg;

  localparam int MAX_CH = 16;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_OUTPUT
  } scan_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } ch_pick_t;

  // Lowest set bit above cur (or at/above cur when incl is set).
  function automatic ch_pick_t next_enabled(input logic [MAX_CH-1:0] mask,
                                            input logic [IDX_W-1:0]  cur,
                                            input logic              incl);
    ch_pick_t p;
    p = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
        p.found = 1'b1;
        p.idx   = IDX_W'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// Sums 2^AVG_LOG2 consecutive codes; o_done/o_avg are valid on the cycle of the last add.
// o_avg includes the current code so the result can be registered on that same edge.
module adc_avg_accum #(
  parameter int AVG_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_code,
  output logic       o_done,
  output logic [7:0] o_avg
);

  localparam int ACC_W = 8 + AVG_LOG2;
  localparam logic [4:0] LAST = 5'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;
  logic [4:0]       r_cnt;

  assign w_sum  = r_acc + ACC_W'(i_code);
  assign o_done = i_en && (r_cnt == LAST);
  assign o_avg  = 8'(w_sum >> AVG_LOG2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + 5'd1;
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Time-shares one 8-bit flash ADC across NUM_CH mux inputs: settle, average, emit per channel.
// Results wait on res_ready indefinitely; the scan stalls rather than drop a result.
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int SETTLE_CYC = 3,
  parameter int AVG_LOG2   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic [7:0]                vref_cfg,
  output logic [7:0]                adc_vref,
  output logic [$clog2(NUM_CH)-1:0] adc_sel,
  input  logic [7:0]                adc_code,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NUM_CH)-1:0] res_ch,
  output logic [7:0]                res_data,
  output logic                      busy
);

  localparam int CH_W = $clog2(NUM_CH);
  // A scan started from IDLE gets one extra settle cycle for the fresh Vref.
  localparam logic [3:0] CNT_FIRST = 4'(SETTLE_CYC);
  localparam logic [3:0] CNT_NEXT  = 4'(SETTLE_CYC - 1);

  scan_state_t       r_state, w_next;
  logic [NUM_CH-1:0] r_mask;
  logic [7:0]        r_vref;
  logic [CH_W-1:0]   r_sel;
  logic [CH_W-1:0]   r_res_ch;
  logic [7:0]        r_res_data;
  logic [3:0]        r_settle_cnt;

  logic       w_load_scan, w_adv, w_cnt_ld, w_acc_clr, w_acc_en, w_acc_done;
  logic [3:0] w_cnt_val;
  logic [7:0] w_avg;
  ch_pick_t   w_low, w_up;

  assign w_low = next_enabled(MAX_CH'(ch_mask), '0, 1'b1);
  assign w_up  = next_enabled(MAX_CH'(r_mask), IDX_W'(r_sel), 1'b0);

  assign adc_vref  = r_vref;
  assign adc_sel   = r_sel;
  assign res_ch    = r_res_ch;
  assign res_data  = r_res_data;
  assign res_valid = (r_state == ST_OUTPUT);
  assign busy      = (r_state != ST_IDLE);

  adc_avg_accum #(.AVG_LOG2(AVG_LOG2)) u_accum (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_acc_clr),
    .i_en  (w_acc_en),
    .i_code(adc_code),
    .o_done(w_acc_done),
    .o_avg (w_avg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load_scan = 1'b0;
    w_adv       = 1'b0;
    w_cnt_ld    = 1'b0;
    w_cnt_val   = CNT_NEXT;
    w_acc_clr   = 1'b0;
    w_acc_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && w_low.found) begin
          w_next      = ST_SETTLE;
          w_load_scan = 1'b1;
          w_cnt_ld    = 1'b1;
          w_cnt_val   = CNT_FIRST;
        end
      end
      ST_SETTLE: begin
        if (r_settle_cnt == 4'd0) begin
          w_next    = ST_SAMPLE;
          w_acc_clr = 1'b1;
        end
      end
      ST_SAMPLE: begin
        w_acc_en = 1'b1;
        if (w_acc_done) w_next = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (res_ready) begin
          if (w_up.found) begin
            w_next   = ST_SETTLE;
            w_adv    = 1'b1;
            w_cnt_ld = 1'b1;
          end else if (continuous && w_low.found) begin
            w_next      = ST_SETTLE;
            w_load_scan = 1'b1;
            w_cnt_ld    = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask       <= '0;
      r_vref       <= '0;
      r_sel        <= '0;
      r_res_ch     <= '0;
      r_res_data   <= '0;
      r_settle_cnt <= '0;
    end else begin
      if (w_load_scan) begin
        r_mask <= ch_mask;
        r_vref <= vref_cfg;
        r_sel  <= CH_W'(w_low.idx);
      end else if (w_adv) begin
        r_sel <= CH_W'(w_up.idx);
      end
      if (w_cnt_ld)
        r_settle_cnt <= w_cnt_val;
      else if ((r_state == ST_SETTLE) && (r_settle_cnt != 4'd0))
        r_settle_cnt <= r_settle_cnt - 4'd1;
      if (w_acc_done) begin
        r_res_data <= w_avg;
        r_res_ch   <= r_sel;
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl: expected (channel, average) pairs are queued at stimulus
// time and a negedge monitor pops one per accepted result.
module tb_adc_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, continuous, res_ready;
  logic [3:0] ch_mask;
  logic [7:0] vref_cfg, adc_vref, adc_code, res_data;
  logic [1:0] adc_sel, res_ch;
  logic       res_valid, busy;

  logic [7:0] tab [4];
  logic       ovr;
  logic [7:0] ovr_code;

  int         checks = 0;
  int         failures = 0;
  logic [9:0] sb [$];

  always #5 clk = ~clk;

  // The converter output follows the mux: a fixed code per channel unless overridden.
  assign adc_code = ovr ? ovr_code : tab[adc_sel];

  adc_scan_ctrl #(.NUM_CH(4), .SETTLE_CYC(3), .AVG_LOG2(2)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .vref_cfg(vref_cfg), .adc_vref(adc_vref),
    .adc_sel(adc_sel), .adc_code(adc_code), .res_valid(res_valid),
    .res_ready(res_ready), .res_ch(res_ch), .res_data(res_data), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin : mon
      logic [9:0] e;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got ch=%0d data=%0d expected none", res_ch, res_data);
      end else begin
        e = sb.pop_front();
        chk("result", {22'd0, res_ch, res_data}, {22'd0, e});
      end
    end
  end

  // Model: one result per enabled channel in ascending order; constant codes average to themselves.
  task automatic push_scan();
    for (int i = 0; i < 4; i++)
      if (ch_mask[i]) sb.push_back({2'(i), tab[i]});
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while ((busy || sb.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_pending"}, sb.size(), 32'd0);
  endtask

  initial begin
    int n, bad, t;
    logic [7:0] d;
    logic [1:0] c, s;
    logic [7:0] v;

    rst = 1'b1; start = 1'b0; continuous = 1'b0; res_ready = 1'b1;
    ch_mask = '0; vref_cfg = '0; ovr = 1'b0; ovr_code = '0;
    tab = '{8'd0, 8'd0, 8'd0, 8'd0};
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_valid", {31'd0, res_valid}, 0);
    chk("rst_sel", {30'd0, adc_sel}, 0);
    chk("rst_vref", {24'd0, adc_vref}, 0);
    chk("rst_data", {24'd0, res_data}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Plain scan over a sparse mask.
    tab = '{8'd10, 8'd20, 8'd0, 8'd200};
    ch_mask = 4'b1011; vref_cfg = 8'd77;
    push_scan();
    pulse_start();
    chk("scan_vref", {24'd0, adc_vref}, 77);
    wait_valid(n);
    chk("first_latency", n, 8);
    t = 0;
    while (!(res_valid && res_ch == 2'd3) && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("busy_after_last", {31'd0, busy}, 0);
    chk("scan1_pending", sb.size(), 0);

    // Averaging truncates; sample window is the 4 cycles before the result.
    ch_mask = 4'b0001; ovr = 1'b1; ovr_code = 8'd99;
    sb.push_back({2'd0, 8'd7});
    pulse_start();
    repeat (4) @(negedge clk);
    ovr_code = 8'd7;
    @(negedge clk) ovr_code = 8'd8;
    wait_done("avg_trunc");
    ovr_code = 8'd255;
    sb.push_back({2'd0, 8'd255});
    pulse_start();
    wait_done("avg_full");
    ovr = 1'b0;

    // Back-pressure on the channel-1 result.
    for (int i = 0; i < 4; i++) tab[i] = 8'($urandom_range(0, 255));
    ch_mask = 4'b1011;
    push_scan();
    pulse_start();
    wait_valid(n);
    @(posedge clk) #2 res_ready = 1'b0;
    wait_valid(n);
    d = res_data; c = res_ch; s = adc_sel; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!res_valid || res_data !== d || res_ch !== c || adc_sel !== s) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_ch", {30'd0, c}, 1);
    @(posedge clk) #2 res_ready = 1'b1;
    wait_done("bp");

    // Continuous single-channel scan; Vref follows only at the wrap.
    tab[0] = 8'($urandom_range(0, 255));
    ch_mask = 4'b0001; vref_cfg = 8'd18; continuous = 1'b1;
    push_scan();
    pulse_start();
    wait_valid(n);
    chk("cont_latency", n, 8);
    push_scan();
    @(negedge clk);
    vref_cfg = 8'd10;
    chk("cont_vref_held", {24'd0, adc_vref}, 18);
    wait_valid(n);
    chk("cont_period1", n + 1, 8);
    push_scan();
    @(negedge clk);
    chk("cont_vref_wrap", {24'd0, adc_vref}, 10);
    continuous = 1'b0;
    wait_valid(n);
    chk("cont_period2", n + 1, 8);
    @(negedge clk);
    chk("cont_stop_busy", {31'd0, busy}, 0);
    chk("cont_pending", sb.size(), 0);

    // Ignored commands: empty mask, start mid-scan, mask change mid-scan.
    ch_mask = 4'b0000;
    pulse_start();
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) bad++;
    end
    chk("empty_mask_idle", bad, 0);
    ch_mask = 4'b1011;
    push_scan();
    pulse_start();
    ch_mask = 4'b0100;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done("restart_ignored");

    // Asynchronous reset mid-SAMPLE, then a clean scan.
    ch_mask = 4'b1011;
    push_scan();
    pulse_start();
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_valid", {31'd0, res_valid}, 0);
    chk("arst_sel", {30'd0, adc_sel}, 0);
    chk("arst_vref", {24'd0, adc_vref}, 0);
    chk("arst_data", {24'd0, res_data}, 0);
    chk("arst_ch", {30'd0, res_ch}, 0);
    sb.delete();
    @(negedge clk) rst = 1'b0;
    push_scan();
    pulse_start();
    wait_valid(n);
    chk("post_rst_latency", n, 8);
    wait_done("post_rst");

    // Randomized masks, codes, Vref and ready.
    for (int it = 0; it < 8; it++) begin
      ch_mask = 4'($urandom_range(1, 15));
      v = 8'($urandom_range(0, 255));
      vref_cfg = v;
      for (int i = 0; i < 4; i++) tab[i] = 8'($urandom_range(0, 255));
      push_scan();
      pulse_start();
      chk("rand_vref", {24'd0, adc_vref}, {24'd0, v});
      t = 0;
      while ((busy || sb.size() != 0) && t < 3000) begin
        @(posedge clk) #2 res_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        t++;
      end
      res_ready = 1'b1;
      chk("rand_done", {31'd0, busy}, 0);
      chk("rand_pending", sb.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Sequencer that shares the single 8-bit flash converter (adc8bit) between NUM_CH analog channels.
- Per enabled channel: drives the input-mux select, waits a settle interval, captures 2^AVG_LOG2 consecutive codes, averages them, and offers the result on a valid/ready port.
- Also owns the converter's Vref setting for the duration of a scan.
- Sits between adc8bit and the host register/readout logic.

Parameters:
- NUM_CH, 4, number of multiplexed channels (2..16).
- SETTLE_CYC, 3, clock cycles waited after a mux change before the first capture (1..15).
- AVG_LOG2, 2, log2 of samples averaged per channel (0..4; 0 = no averaging).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a scan when idle.
- continuous  in  1  1 = restart the scan automatically after the last channel.
- ch_mask  in  NUM_CH  channel enables, bit i = channel i.
- vref_cfg  in  8  reference code for the scan.
- adc_vref  out  8  Vref driven to adc8bit.
- adc_sel  out  $clog2(NUM_CH)  analog mux select.
- adc_code  in  8  digital_out from adc8bit (combinational, valid every cycle).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_ch  out  $clog2(NUM_CH)  channel of the result.
- res_data  out  8  averaged code.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; accumulator 0.
  - Reset mid-scan aborts immediately and drops any pending result; no partial result is emitted.
- FSM states: IDLE, SETTLE, SAMPLE, OUTPUT.
- IDLE:
  - On start=1 with ch_mask!=0: latch ch_mask and vref_cfg, adc_vref <= latched vref_cfg, adc_sel <= lowest enabled channel, go to SETTLE.
  - start with ch_mask==0 is ignored.
  - start outside IDLE is ignored.
- SETTLE:
  - Count SETTLE_CYC cycles, then go to SAMPLE with accumulator cleared.
- SAMPLE:
  - Add adc_code into the (8+AVG_LOG2)-bit accumulator each cycle for exactly 2^AVG_LOG2 cycles. The accumulator never overflows.
  - Then res_data <= accumulator >> AVG_LOG2 (truncation, no rounding), res_ch <= adc_sel, go to OUTPUT.
- OUTPUT:
  - res_valid=1. res_data and res_ch are held stable until res_valid&&res_ready.
  - Back-pressure stalls the scan. Results are never dropped or overwritten.
  - On handshake, select the next channel:
    - If there is a higher enabled channel in the latched mask: adc_sel <= next enabled channel, go to SETTLE.
    - Else if continuous=1 (sampled at the handshake cycle): re-latch ch_mask/vref_cfg, select the lowest enabled channel, go to SETTLE. If the new mask is 0, go to IDLE.
    - Else go to IDLE.
- Latency:
  - With start sampled at edge k, res_valid first rises after edge k+1+SETTLE_CYC+2^AVG_LOG2.
  - Defaults: 8 cycles after start.
  - Per-channel period with res_ready tied high: SETTLE_CYC+2^AVG_LOG2+1 cycles.
- Boundaries:
  - A single enabled channel is scanned alone.
  - Mask changes during a scan do not affect it; the mask is re-latched only at wrap.
  - adc_sel changes only on entry to SETTLE.
  - Dropping continuous ends the scan after the current last channel; no mid-scan stop.

Decomposition:
- Package adc_scan_pkg:
  - FSM state enum.
  - Localparams CH_W=$clog2(NUM_CH) and ACC_W=8+AVG_LOG2.
  - Function next_enabled(mask, cur) returning the next set bit above cur plus a found flag.
- One natural sub-module: adc_avg_accum (clear, enable, sample count, done flag, shifted result).
- Mask search and FSM stay in the top.

Test Plan:
- Single scan, mask=4'b1011, codes ch0=10, ch1=20, ch3=200, res_ready=1 → results (0,10), (1,20), (3,200), in that order; first res_valid 8 cycles after start; busy drops after the last handshake.
- Averaging, AVG_LOG2=2: ch0 code sequence 7,8,8,8 during SAMPLE → res_data=7 (31>>2, truncated); 255×4 → 255, no overflow.
- Back-pressure: res_ready=0 for 20 cycles on ch1's result → res_valid, res_data and res_ch stable throughout; adc_sel unchanged; ch3 result follows after release.
- Continuous: continuous=1, mask=4'b0001, vref_cfg=18 → repeated ch0 results every 8 cycles; changing vref_cfg to 10 mid-scan updates adc_vref only at the wrap; clearing continuous → IDLE after the next result.
- Ignored commands: start with mask=0 → busy stays 0. start pulse during SAMPLE → no restart, sequence unchanged.
- Async reset asserted mid-SAMPLE (between clock edges) → all outputs 0 immediately; the next start runs a clean scan.
